// File: rtl/snap_regload.sv
// Snapshot register-restore engine: captures Z80 register bytes from the loader stream,
// drives the T80 DIR port and holds the CPU in reset until vsync. SP fix-up under `SNAP_SPFIX_EN`.
module snap_regload #(
   parameter logic [7:0]  REG_PAGE       = 8'h21,
   parameter int unsigned SET_CYCLES     = 2,
   parameter int unsigned RELEASE_FRAMES = 1,
   parameter logic [15:0] SP_FIX_VALUE   = 16'hFFFE
) (
   input  logic         clk_i,
   input  logic         reset_n_i,
   input  logic         loader_en_i,
   input  logic [15:0]  loader_addr_i,
   input  logic [7:0]   loader_data_i,
   input  logic         loader_wr_i,
   input  logic         vsync_i,
   output logic         cpu_reset_o,
   output logic         dir_set_o,
   output logic [211:0] dir_o,
   output logic         pc_seen_o
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_APPLY,
      ST_WAIT_SYNC,
      ST_RUN
   } state_e;

   localparam logic [3:0] SET_CYCLES_C = 4'(SET_CYCLES);
   localparam logic [2:0] RELEASE_C    = 3'(RELEASE_FRAMES);

   state_e         state_q, state_d;
   logic [211:0]   dir_q, dir_d;
   logic           pcl_seen_q, pcl_seen_d;
   logic           pch_seen_q, pch_seen_d;
   logic           pc_seen_q, pc_seen_d;
   logic [3:0]     set_cnt_q, set_cnt_d;
   logic [2:0]     frame_cnt_q, frame_cnt_d;
   logic           vsync_q;
   logic           cpu_reset_q, cpu_reset_d;
   logic           dir_set_q, dir_set_d;
   logic           reg_wr;
   logic           vsync_rise;

`ifdef SNAP_SPFIX_EN
   logic [15:0]    end_addr_q, end_addr_d;
`else
   logic           unused_sp_fix;
   assign unused_sp_fix = ^SP_FIX_VALUE;
`endif

   assign reg_wr     = loader_wr_i && (loader_addr_i[15:8] == REG_PAGE) && !loader_addr_i[7];
   assign vsync_rise = vsync_i && !vsync_q;

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      dir_d       = dir_q;
      pcl_seen_d  = pcl_seen_q;
      pch_seen_d  = pch_seen_q;
      set_cnt_d   = set_cnt_q;
      frame_cnt_d = frame_cnt_q;
`ifdef SNAP_SPFIX_EN
      end_addr_d  = end_addr_q;
`endif

      // A new session pre-empts whatever the engine was doing.
      if (loader_en_i && (state_q != ST_LOAD)) begin
         state_d     = ST_LOAD;
         dir_d       = '0;
         pcl_seen_d  = 1'b0;
         pch_seen_d  = 1'b0;
         set_cnt_d   = '0;
         frame_cnt_d = '0;
`ifdef SNAP_SPFIX_EN
         end_addr_d  = '0;
`endif
      end else begin
         unique case (state_q)
            ST_IDLE: ;

            ST_LOAD: begin
`ifdef SNAP_SPFIX_EN
               if (loader_wr_i) end_addr_d = loader_addr_i;
`endif
               if (reg_wr) begin
                  case (loader_addr_i[6:0])
                     7'h00: dir_d[15:8]    = loader_data_i;
                     7'h01: dir_d[7:0]     = loader_data_i;
                     7'h04: dir_d[87:80]   = loader_data_i;
                     7'h05: dir_d[95:88]   = loader_data_i;
                     7'h08: dir_d[103:96]  = loader_data_i;
                     7'h09: dir_d[111:104] = loader_data_i;
                     7'h0C: dir_d[119:112] = loader_data_i;
                     7'h0D: dir_d[127:120] = loader_data_i;
                     7'h10: dir_d[135:128] = loader_data_i;
                     7'h11: dir_d[143:136] = loader_data_i;
                     7'h14: dir_d[199:192] = loader_data_i;
                     7'h15: dir_d[207:200] = loader_data_i;
                     7'h18: dir_d[55:48]   = loader_data_i;
                     7'h19: dir_d[63:56]   = loader_data_i;
                     7'h1C: begin
                        dir_d[71:64] = loader_data_i;
                        pcl_seen_d   = 1'b1;
                     end
                     7'h1D: begin
                        dir_d[79:72] = loader_data_i;
                        pch_seen_d   = 1'b1;
                     end
                     7'h20: dir_d[31:24]   = loader_data_i;
                     7'h21: dir_d[23:16]   = loader_data_i;
                     7'h24: dir_d[151:144] = loader_data_i;
                     7'h25: dir_d[159:152] = loader_data_i;
                     7'h28: dir_d[167:160] = loader_data_i;
                     7'h29: dir_d[175:168] = loader_data_i;
                     7'h2C: dir_d[183:176] = loader_data_i;
                     7'h2D: dir_d[191:184] = loader_data_i;
                     7'h30: dir_d[209:208] = loader_data_i[1:0];
                     7'h34: dir_d[210]     = loader_data_i[0];
                     7'h38: dir_d[211]     = loader_data_i[0];
                     7'h3C: dir_d[39:32]   = loader_data_i;
                     7'h40: dir_d[47:40]   = loader_data_i;
                     default: ;
                  endcase
               end
               if (!loader_en_i) begin
                  state_d   = ST_APPLY;
                  set_cnt_d = SET_CYCLES_C;
               end
            end

            ST_APPLY: begin
`ifdef SNAP_SPFIX_EN
               // A stack pointer above the last loaded byte points at garbage.
               if ((set_cnt_q == SET_CYCLES_C) && (dir_q[63:48] > end_addr_q))
                  dir_d[63:48] = SP_FIX_VALUE;
`endif
               set_cnt_d = set_cnt_q - 4'd1;
               if (set_cnt_q <= 4'd1) begin
                  state_d     = ST_WAIT_SYNC;
                  frame_cnt_d = '0;
               end
            end

            ST_WAIT_SYNC: begin
               if (vsync_rise) begin
                  frame_cnt_d = frame_cnt_q + 3'd1;
                  if ((frame_cnt_q + 3'd1) == RELEASE_C) state_d = ST_RUN;
               end
            end

            ST_RUN: ;

            default: state_d = ST_IDLE;
         endcase
      end

      pc_seen_d   = pcl_seen_d && pch_seen_d;
      cpu_reset_d = (state_d == ST_LOAD) || (state_d == ST_APPLY) || (state_d == ST_WAIT_SYNC);
      dir_set_d   = (state_d == ST_APPLY);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= ST_IDLE;
         dir_q       <= '0;
         pcl_seen_q  <= 1'b0;
         pch_seen_q  <= 1'b0;
         pc_seen_q   <= 1'b0;
         set_cnt_q   <= '0;
         frame_cnt_q <= '0;
         vsync_q     <= 1'b0;
         cpu_reset_q <= 1'b0;
         dir_set_q   <= 1'b0;
`ifdef SNAP_SPFIX_EN
         end_addr_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         dir_q       <= dir_d;
         pcl_seen_q  <= pcl_seen_d;
         pch_seen_q  <= pch_seen_d;
         pc_seen_q   <= pc_seen_d;
         set_cnt_q   <= set_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         vsync_q     <= vsync_i;
         cpu_reset_q <= cpu_reset_d;
         dir_set_q   <= dir_set_d;
`ifdef SNAP_SPFIX_EN
         end_addr_q  <= end_addr_d;
`endif
      end
   end

   assign cpu_reset_o = cpu_reset_q;
   assign dir_set_o   = dir_set_q;
   assign dir_o       = dir_q;
   assign pc_seen_o   = pc_seen_q;

endmodule

// File: tb/tb_snap_regload.sv
// Self-checking bench for snap_regload: table-driven register decode with a scoreboard queue,
// plus hand-written sequences for APPLY/WAIT_SYNC timing, SP fix-up, restart and reset.
module tb_snap_regload;

   logic         clk_i = 1'b0;
   logic         reset_n_i;
   logic         loader_en_i;
   logic [15:0]  loader_addr_i;
   logic [7:0]   loader_data_i;
   logic         loader_wr_i;
   logic         vsync_i;
   logic         cpu_reset_o;
   logic         dir_set_o;
   logic [211:0] dir_o;
   logic         pc_seen_o;

   snap_regload #(
      .REG_PAGE       (8'h21),
      .SET_CYCLES     (2),
      .RELEASE_FRAMES (2),
      .SP_FIX_VALUE   (16'hFFFE)
   ) dut (
      .clk_i         (clk_i),
      .reset_n_i     (reset_n_i),
      .loader_en_i   (loader_en_i),
      .loader_addr_i (loader_addr_i),
      .loader_data_i (loader_data_i),
      .loader_wr_i   (loader_wr_i),
      .vsync_i       (vsync_i),
      .cpu_reset_o   (cpu_reset_o),
      .dir_set_o     (dir_set_o),
      .dir_o         (dir_o),
      .pc_seen_o     (pc_seen_o)
   );

   always #5 clk_i = ~clk_i;

`ifdef SNAP_SPFIX_EN
   localparam logic [15:0] SP_HIGH_EXP = 16'hFFFE;
`else
   localparam logic [15:0] SP_HIGH_EXP = 16'h8000;
`endif

   // One loader byte: where it lands in dir (lo) and how many data bits it carries (w, 0 = ignored).
   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
      int          lo;
      int          w;
   } vec_t;

   vec_t         vecs [0:32];
   logic [211:0] exp_dir;
   logic [211:0] sb_q [$];
   int           n_checks = 0;
   int           n_pass   = 0;

   task automatic check(input string name, input logic [211:0] act, input logic [211:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_write(input logic [15:0] addr, input logic [7:0] data, input int lo, input int w);
      logic [211:0] exp;
      loader_wr_i   = 1'b1;
      loader_addr_i = addr;
      loader_data_i = data;
      for (int b = 0; b < w; b++) exp_dir[lo + b] = data[b];
      sb_q.push_back(exp_dir);
      tick();
      loader_wr_i = 1'b0;
      if (sb_q.size() == 0) begin
         check("scoreboard_empty", 1'b1, 1'b0);
      end else begin
         exp = sb_q.pop_front();
         check($sformatf("dir_after_wr_%h", addr), dir_o, exp);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs = '{
         '{16'h2100, 8'h11,   8, 8}, '{16'h2101, 8'h22,   0, 8},
         '{16'h2104, 8'h33,  80, 8}, '{16'h2105, 8'h44,  88, 8},
         '{16'h2108, 8'h55,  96, 8}, '{16'h2109, 8'h66, 104, 8},
         '{16'h210C, 8'h77, 112, 8}, '{16'h210D, 8'h88, 120, 8},
         '{16'h2110, 8'h99, 128, 8}, '{16'h2111, 8'hAA, 136, 8},
         '{16'h2114, 8'hBB, 192, 8}, '{16'h2115, 8'hCC, 200, 8},
         '{16'h2118, 8'h00,  48, 8}, '{16'h2119, 8'h10,  56, 8},
         '{16'h211C, 8'h34,  64, 8}, '{16'h211D, 8'h12,  72, 8},
         '{16'h2120, 8'hA5,  24, 8}, '{16'h2121, 8'h5A,  16, 8},
         '{16'h2124, 8'hC1, 144, 8}, '{16'h2125, 8'hB2, 152, 8},
         '{16'h2128, 8'hE3, 160, 8}, '{16'h2129, 8'hD4, 168, 8},
         '{16'h212C, 8'h65, 176, 8}, '{16'h212D, 8'h76, 184, 8},
         '{16'h2130, 8'hFE, 208, 2}, '{16'h2134, 8'h01, 210, 1},
         '{16'h2138, 8'h03, 211, 1}, '{16'h213C, 8'h3F,  32, 8},
         '{16'h2140, 8'h7E,  40, 8}, '{16'h2180, 8'hFF,   0, 0},
         '{16'h2102, 8'hFF,   0, 0}, '{16'h2221, 8'hFF,   0, 0},
         '{16'h2021, 8'hFF,   0, 0}
      };

      reset_n_i     = 1'b0;
      loader_en_i   = 1'b0;
      loader_addr_i = '0;
      loader_data_i = '0;
      loader_wr_i   = 1'b0;
      vsync_i       = 1'b0;
      exp_dir       = '0;

      tick();
      tick();
      check("rst_cpu_reset", cpu_reset_o, 1'b0);
      check("rst_dir_set",   dir_set_o,   1'b0);
      check("rst_dir",       dir_o,       '0);
      check("rst_pc_seen",   pc_seen_o,   1'b0);
      reset_n_i = 1'b1;
      tick();
      check("idle_cpu_reset", cpu_reset_o, 1'b0);
      check("idle_dir_set",   dir_set_o,   1'b0);

      // Session 1: full register decode, then release timing.
      loader_en_i = 1'b1;
      tick();
      check("load_cpu_reset", cpu_reset_o, 1'b1);
      check("load_dir_set",   dir_set_o,   1'b0);
      check("load_dir_clear", dir_o,       '0);
      for (int i = 0; i < 33; i++) do_write(vecs[i].addr, vecs[i].data, vecs[i].lo, vecs[i].w);
      check("s1_a_alt",   dir_o[23:16], 8'h5A);
      check("s1_pc",      dir_o[79:64], 16'h1234);
      check("s1_pc_seen", pc_seen_o,    1'b1);

      begin
         int set_cnt;
         bit done;
         loader_en_i = 1'b0;
         tick();
         check("apply_dir_set_rise", dir_set_o, 1'b1);
         vsync_i = 1'b1;      // edge during APPLY, must not be counted
         set_cnt = 1;
         done    = 1'b0;
         for (int i = 0; i < 20 && !done; i++) begin
            tick();
            vsync_i = 1'b0;
            if (dir_set_o) set_cnt++;
            else done = 1'b1;
         end
         check("dir_set_fell", done, 1'b1);
         check("dir_set_cycles", set_cnt, 2);
      end
      check("wait_cpu_reset", cpu_reset_o, 1'b1);
      tick();
      vsync_i = 1'b1;
      tick();
      check("after_edge1_cpu_reset", cpu_reset_o, 1'b1);
      vsync_i = 1'b0;
      tick();
      check("before_edge2_cpu_reset", cpu_reset_o, 1'b1);
      vsync_i = 1'b1;
      tick();
      check("after_edge2_cpu_reset", cpu_reset_o, 1'b0);
      check("run_dir_set",           dir_set_o,   1'b0);
      vsync_i = 1'b0;
      tick();
      check("run_dir_hold",     dir_o,     exp_dir);
      check("run_pc_seen_hold", pc_seen_o, 1'b1);

      // Session 2: SP above the end address.
      loader_en_i = 1'b1;
      exp_dir     = '0;
      tick();
      check("s2_dir_clear", dir_o,     '0);
      check("s2_pc_seen",   pc_seen_o, 1'b0);
      do_write(16'h2118, 8'h00, 48, 8);
      do_write(16'h2119, 8'h80, 56, 8);
      do_write(16'h211C, 8'h99, 64, 8);
      do_write(16'h3FFF, 8'h00,  0, 0);
      check("s2_pc_half_seen", pc_seen_o, 1'b0);
      loader_en_i = 1'b0;
      tick();
      check("s2_sp_first_apply", dir_o[63:48], 16'h8000);
      tick();
      check("s2_sp_second_apply", dir_o[63:48], SP_HIGH_EXP);
      tick();
      check("s2_wait_dir_set", dir_set_o, 1'b0);

      // Session 3: SP below the end address, then restart on the release edge.
      loader_en_i = 1'b1;
      exp_dir     = '0;
      tick();
      check("s3_dir_clear", dir_o, '0);
      do_write(16'h2118, 8'h00, 48, 8);
      do_write(16'h2119, 8'h30, 56, 8);
      do_write(16'h211C, 8'hCD, 64, 8);
      do_write(16'h211D, 8'hAB, 72, 8);
      do_write(16'h3FFF, 8'h00,  0, 0);
      check("s3_pc_seen", pc_seen_o, 1'b1);
      loader_en_i = 1'b0;
      tick();
      tick();
      check("s3_sp_kept", dir_o[63:48], 16'h3000);
      tick();
      check("s3_wait_cpu_reset", cpu_reset_o, 1'b1);
      vsync_i = 1'b1;
      tick();
      vsync_i = 1'b0;
      tick();
      vsync_i     = 1'b1;
      loader_en_i = 1'b1;
      tick();
      vsync_i = 1'b0;
      check("restart_cpu_reset", cpu_reset_o, 1'b1);
      check("restart_dir_set",   dir_set_o,   1'b0);
      check("restart_dir_clear", dir_o,       '0);
      check("restart_pc_seen",   pc_seen_o,   1'b0);
      exp_dir = '0;
      do_write(16'h2101, 8'hEE, 0, 8);

      // Asynchronous reset in the middle of LOAD.
      #2;
      reset_n_i = 1'b0;
      #1;
      check("arst_cpu_reset", cpu_reset_o, 1'b0);
      check("arst_dir_set",   dir_set_o,   1'b0);
      check("arst_dir",       dir_o,       '0);
      check("arst_pc_seen",   pc_seen_o,   1'b0);
      loader_en_i = 1'b0;
      tick();
      reset_n_i = 1'b1;
      tick();
      tick();
      check("post_rst_cpu_reset", cpu_reset_o, 1'b0);
      check("post_rst_dir_set",   dir_set_o,   1'b0);
      check("post_rst_dir",       dir_o,       '0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
